player_action_fsm: RTL and testbench

//  Per-player action state machine; drives the state/x interface that the hit detector consumes.

---
 rtl/player_action_fsm.sv | 177 +++++++++++++++++
 tb/tb_player_action_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/player_action_fsm.sv
// Per-player action FSM: buttons -> state code and clamped x, with stun/dead handling.
// Latency: state and x update on the clk edge where frame_tick=1 and are held between ticks.
// Backpressure: none; every frame_tick is consumed, and an opp_hit edge is latched until the next tick.
module player_action_fsm #(
    parameter int unsigned PLAYER_ID   = 0,
    parameter int unsigned X_INIT      = 64,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 576,
    parameter int unsigned FWD_STEP    = 3,
    parameter int unsigned BWD_STEP    = 2,
    parameter int unsigned MIN_GAP     = 64,
    parameter int unsigned STARTUP_FR  = 5,
    parameter int unsigned ACTIVE_FR   = 2,
    parameter int unsigned RECOVERY_FR = 16,
    parameter int unsigned STUN_FR     = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic [9:0] opp_x,
    input  logic       opp_hit,
    input  logic       lives_zero,
    output logic [3:0] state,
    output logic [9:0] x
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_MOVE_FWD  = 4'd1,
        ST_MOVE_BWD  = 4'd2,
        ST_ATK_START = 4'd5,
        ST_ATK_ACT   = 4'd6,
        ST_ATK_REC   = 4'd7,
        ST_STUN      = 4'd8,
        ST_DEAD      = 4'd9
    } state_t;

    // Position math is done in 11 bits so opp_x + MIN_GAP can never wrap.
    localparam logic [10:0] L_XMIN = 11'(X_MIN);
    localparam logic [10:0] L_XMAX = 11'(X_MAX);
    localparam logic [10:0] L_FWD  = 11'(FWD_STEP);
    localparam logic [10:0] L_BWD  = 11'(BWD_STEP);
    localparam logic [10:0] L_GAP  = 11'(MIN_GAP);
    localparam logic [7:0]  C_START = 8'(STARTUP_FR);
    localparam logic [7:0]  C_ACT   = 8'(ACTIVE_FR);
    localparam logic [7:0]  C_REC   = 8'(RECOVERY_FR);
    localparam logic [7:0]  C_STUN  = 8'(STUN_FR);

    state_t      st;
    logic [7:0]  cnt;
    logic        stun_pend;
    logic        hit_q;
    logic        atk_q;

    logic        hit_rise;
    logic        stun_now;
    logic        atk_press;
    logic        fwd_req;
    logic        bwd_req;
    logic [10:0] x11;
    logic [10:0] opp11;
    logic [10:0] fwd_lim;
    logic [10:0] near_lim;
    logic [10:0] x_fwd;
    logic [10:0] x_bwd;

    assign state = st;

    // Event detection and next-x candidates for forward/backward motion.
    always_comb begin
        hit_rise  = opp_hit & ~hit_q;
        stun_now  = stun_pend | hit_rise;
        atk_press = btn_attack & ~atk_q;
        if (PLAYER_ID == 0) begin
            fwd_req = btn_right & ~btn_left;
            bwd_req = btn_left & ~btn_right;
        end else begin
            fwd_req = btn_left & ~btn_right;
            bwd_req = btn_right & ~btn_left;
        end
        x11      = {1'b0, x};
        opp11    = {1'b0, opp_x};
        fwd_lim  = L_XMIN;
        near_lim = L_XMIN;
        x_fwd    = x11;
        x_bwd    = x11;
        if (PLAYER_ID == 0) begin
            // Forward is +x: stop at MIN_GAP short of the opponent or at X_MAX.
            fwd_lim = (opp11 < L_GAP) ? L_XMIN : (opp11 - L_GAP);
            if (fwd_lim > L_XMAX) fwd_lim = L_XMAX;
            if (x11 >= fwd_lim)                x_fwd = x11;
            else if (x11 + L_FWD >= fwd_lim)   x_fwd = fwd_lim;
            else                               x_fwd = x11 + L_FWD;
            // Backward is -x, saturating at X_MIN.
            if (x11 <= L_XMIN)                 x_bwd = x11;
            else if (x11 < L_XMIN + L_BWD)     x_bwd = L_XMIN;
            else                               x_bwd = x11 - L_BWD;
        end else begin
            // Forward is -x: stop at MIN_GAP past the opponent, within the screen.
            near_lim = opp11 + L_GAP;
            if (near_lim > L_XMAX) near_lim = L_XMAX;
            fwd_lim = (near_lim < L_XMIN) ? L_XMIN : near_lim;
            if (x11 <= fwd_lim)                x_fwd = x11;
            else if (x11 < fwd_lim + L_FWD)    x_fwd = fwd_lim;
            else                               x_fwd = x11 - L_FWD;
            // Backward is +x, saturating at X_MAX.
            if (x11 >= L_XMAX)                 x_bwd = x11;
            else if (x11 + L_BWD > L_XMAX)     x_bwd = L_XMAX;
            else                               x_bwd = x11 + L_BWD;
        end
    end

    // Action state machine; all state and x updates are gated by frame_tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= ST_IDLE;
            x         <= 10'(X_INIT);
            cnt       <= '0;
            stun_pend <= 1'b0;
            hit_q     <= 1'b0;
            atk_q     <= 1'b0;
        end else begin
            hit_q <= opp_hit;
            if (hit_rise) stun_pend <= 1'b1;
            if (frame_tick) begin
                atk_q     <= btn_attack;
                stun_pend <= 1'b0;
                if (st == ST_DEAD || lives_zero) begin
                    st <= ST_DEAD;
                end else if (stun_now) begin
                    st  <= ST_STUN;
                    cnt <= C_STUN;
                end else begin
                    case (st)
                        ST_IDLE, ST_MOVE_FWD, ST_MOVE_BWD: begin
                            if (atk_press) begin
                                st  <= ST_ATK_START;
                                cnt <= C_START;
                            end else if (fwd_req) begin
                                st <= ST_MOVE_FWD;
                                x  <= x_fwd[9:0];
                            end else if (bwd_req) begin
                                st <= ST_MOVE_BWD;
                                x  <= x_bwd[9:0];
                            end else begin
                                st <= ST_IDLE;
                            end
                        end
                        ST_ATK_START: begin
                            if (cnt <= 8'd1) begin
                                st  <= ST_ATK_ACT;
                                cnt <= C_ACT;
                            end else cnt <= cnt - 8'd1;
                        end
                        ST_ATK_ACT: begin
                            if (cnt <= 8'd1) begin
                                st  <= ST_ATK_REC;
                                cnt <= C_REC;
                            end else cnt <= cnt - 8'd1;
                        end
                        ST_ATK_REC, ST_STUN: begin
                            if (cnt <= 8'd1) begin
                                st  <= ST_IDLE;
                                cnt <= '0;
                            end else cnt <= cnt - 8'd1;
                        end
                        default: st <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_player_action_fsm.sv
// Directed bench for player_action_fsm: vector table plus hand-written multi-tick sequences.
// Latency: one frame_tick per step; outputs checked on the falling edge after the tick.
// Backpressure: n/a.
module tb_player_action_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       btn_left, btn_right, btn_attack;
    logic [9:0] opp_x;
    logic       opp_hit, lives_zero;
    logic [3:0] state;
    logic [9:0] x;

    logic       p1_left, p1_right;
    logic [9:0] p1_opp_x;
    logic [3:0] p1_state;
    logic [9:0] p1_x;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    player_action_fsm #(.PLAYER_ID(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
        .opp_x(opp_x), .opp_hit(opp_hit), .lives_zero(lives_zero),
        .state(state), .x(x)
    );

    player_action_fsm #(.PLAYER_ID(1), .X_INIT(570)) dut1 (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .btn_left(p1_left), .btn_right(p1_right), .btn_attack(1'b0),
        .opp_x(p1_opp_x), .opp_hit(1'b0), .lives_zero(1'b0),
        .state(p1_state), .x(p1_x)
    );

    typedef struct {
        logic       l;
        logic       r;
        logic       a;
        logic [3:0] st;
        logic [9:0] xp;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_attack = 1'b0;
        opp_x = 10'd400; opp_hit = 1'b0; lives_zero = 1'b0;
        p1_left = 1'b0; p1_right = 1'b0; p1_opp_x = 10'd100;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 4'd1, 10'd67};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd1, 10'd70};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd1, 10'd73};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 4'd0, 10'd73};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd2, 10'd71};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 4'd2, 10'd69};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 4'd0, 10'd69};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 4'd5, 10'd69};

        repeat (3) @(negedge clk);
        check("reset_state", state, 0);
        check("reset_x", x, 64);
        check("reset_p1_x", p1_x, 570);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Movement, both-buttons idle and attack press from the table.
        for (int i = 0; i < 8; i++) begin
            btn_left = tbl[i].l; btn_right = tbl[i].r; btn_attack = tbl[i].a;
            tick();
            check($sformatf("vec%0d_state", i), state, tbl[i].st);
            check($sformatf("vec%0d_x", i), x, tbl[i].xp);
        end

        // Held attack runs the full 5/2/16 sequence once and never re-triggers.
        for (int k = 2; k <= 30; k++) begin
            int e;
            tick();
            e = (k <= 5) ? 5 : (k <= 7) ? 6 : (k <= 23) ? 7 : 0;
            check($sformatf("atk_t%0d_state", k), state, e);
        end
        check("atk_x", x, 69);

        // Hit during ATK_START aborts into a 15-tick stun; buttons ignored.
        btn_attack = 1'b0; tick();
        check("prestun_state", state, 0);
        btn_attack = 1'b1; tick();
        check("stun_start1", state, 5);
        tick();
        check("stun_start2", state, 5);
        @(negedge clk); opp_hit = 1'b1;
        repeat (2) @(negedge clk); opp_hit = 1'b0;
        btn_attack = 1'b0; btn_right = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            check($sformatf("stun_t%0d_state", j), state, (j <= 15) ? 8 : 0);
        end
        check("stun_x", x, 69);
        btn_right = 1'b0;

        // Asynchronous reset in the middle of ATK_ACT.
        btn_attack = 1'b1;
        repeat (6) tick();
        check("pre_reset_act", state, 6);
        @(negedge clk); #1 reset_n = 1'b0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_x", x, 64);
        btn_attack = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_state", state, 0);
        check("hold_x", x, 64);

        // P0 forward clamps at opp_x - MIN_GAP = 336.
        btn_right = 1'b1;
        for (int k = 1; k <= 95; k++) begin
            int e;
            tick();
            e = (64 + 3 * k > 336) ? 336 : 64 + 3 * k;
            check($sformatf("clamp_t%0d_x", k), x, e);
            check($sformatf("clamp_t%0d_state", k), state, 1);
        end
        btn_right = 1'b0;

        // P1 backward saturates at X_MAX, then forward moves -x.
        p1_right = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            int e;
            tick();
            e = (570 + 2 * k > 576) ? 576 : 570 + 2 * k;
            check($sformatf("p1_bwd_t%0d_x", k), p1_x, e);
            check($sformatf("p1_bwd_t%0d_state", k), p1_state, 2);
        end
        p1_right = 1'b0; p1_left = 1'b1;
        tick();
        check("p1_fwd1_x", p1_x, 573);
        check("p1_fwd1_state", p1_state, 1);
        tick();
        check("p1_fwd2_x", p1_x, 570);
        p1_left = 1'b0;
        check("p0_idle_x", x, 336);

        // DEAD is terminal and freezes x until reset.
        lives_zero = 1'b1; btn_right = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            btn_attack = k[0];
            tick();
            check($sformatf("dead_t%0d_state", k), state, 9);
            check($sformatf("dead_t%0d_x", k), x, 336);
        end
        lives_zero = 1'b0; btn_attack = 1'b0;
        tick();
        btn_attack = 1'b1;
        tick();
        check("dead_sticky_state", state, 9);
        check("dead_sticky_x", x, 336);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("dead_reset_state", state, 0);
        check("dead_reset_x", x, 64);
        @(negedge clk); reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
